// File: rtl/mem_stage_if.sv
// Bundle between the EXE/MEM pipeline register, the MEM stage and the MEM/WB register.
// The pipeline side drives through master; mem_stage consumes through slave.
interface mem_stage_if;
  // Pipeline to MEM stage
  logic        WB_en_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic [31:0] ALU_result_in;
  logic [31:0] ST_val_in;
  logic [4:0]  Dest_in;

  // MEM stage to MEM/WB register and freeze logic
  logic        WB_en;
  logic        MEM_R_EN;
  logic [31:0] ALU_result;
  logic [31:0] MEM_read_value;
  logic [4:0]  Dest;
  logic        ready;
  logic        addr_err;

  modport master (
    output WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in,
    input  WB_en, MEM_R_EN, ALU_result, MEM_read_value, Dest, ready, addr_err
  );

  modport slave (
    input  WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in,
    output WB_en, MEM_R_EN, ALU_result, MEM_read_value, Dest, ready, addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: internal word memory with fixed multi-cycle access and ready/freeze handshake.
// Optional range check enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage #(
  parameter int BASE_ADDR = 1024,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int LATENCY   = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_stage_if.slave    bus
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                oor_q, oor_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [31:0]         off;
  logic                req;
  logic                commit;
  logic                oor_now;
  logic                unused_off;

  assign off        = bus.ALU_result_in - 32'(BASE_ADDR);
  assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};
  assign req        = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
  assign commit     = (state_q == BUSY) && (cnt_q == '0);

`ifdef MEM_ADDR_CHECK_EN
  localparam logic [31:0] LO_ADDR = 32'(BASE_ADDR);
  localparam logic [31:0] HI_ADDR = 32'(BASE_ADDR + 4 * DEPTH);
  assign oor_now = (bus.ALU_result_in < LO_ADDR) || (bus.ALU_result_in >= HI_ADDR);
`else
  assign oor_now = 1'b0;
`endif

  // State and latched access fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      oor_q   <= oor_d;
    end
  end

  // Memory is never cleared; a reset on the commit edge cancels the store
  always_ff @(posedge clk) begin
    if (!rst && commit && wr_q && !oor_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    oor_d   = oor_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          idx_d   = off[ADDR_W+1:2];
          wdata_d = bus.ST_val_in;
          wr_d    = bus.MEM_W_EN_in;
          // A simultaneous read+write request behaves as a store only
          rd_d    = bus.MEM_R_EN_in & ~bus.MEM_W_EN_in;
          oor_d   = oor_now;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (rd_q) begin
            rdata_d = oor_q ? 32'hDEAD_BEEF : mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.ready          = (state_q == DONE) || ((state_q == IDLE) && !req);
    bus.MEM_read_value = ((state_q == DONE) && rd_q) ? rdata_q : '0;
    bus.WB_en          = bus.WB_en_in & bus.ready;
    bus.MEM_R_EN       = bus.MEM_R_EN_in;
    bus.ALU_result     = bus.ALU_result_in;
    bus.Dest           = bus.Dest_in;
`ifdef MEM_ADDR_CHECK_EN
    bus.addr_err       = (state_q == DONE) && oor_q;
`else
    bus.addr_err       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, passthrough, store/load timing, reset on commit,
// back-to-back accesses and address wrap / range check.
module tb_mem_stage;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(
    .BASE_ADDR (1024),
    .DEPTH     (64),
    .ADDR_W    (6),
    .LATENCY   (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_idle(input logic wb, input logic [31:0] alu, input logic [4:0] dst);
    bus.WB_en_in      = wb;
    bus.MEM_R_EN_in   = 1'b0;
    bus.MEM_W_EN_in   = 1'b0;
    bus.ALU_result_in = alu;
    bus.ST_val_in     = 32'h0;
    bus.Dest_in       = dst;
  endtask

  task automatic drive_op(input logic r, input logic w, input logic [31:0] addr,
                          input logic [31:0] data);
    bus.WB_en_in      = r;
    bus.MEM_R_EN_in   = r;
    bus.MEM_W_EN_in   = w;
    bus.ALU_result_in = addr;
    bus.ST_val_in     = data;
    bus.Dest_in       = 5'd9;
  endtask

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic do_op(input string tag, input logic r, input logic w,
                       input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rv, output int low, output logic wb_done,
                       output logic err_done, output logic ren_done, output int wb_leak);
    logic seen;
    seen     = 1'b0;
    low      = 0;
    wb_leak  = 0;
    rv       = 32'hx;
    wb_done  = 1'bx;
    err_done = 1'bx;
    ren_done = 1'bx;
    drive_op(r, w, addr, data);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        seen     = 1'b1;
        rv       = bus.MEM_read_value;
        wb_done  = bus.WB_en;
        err_done = bus.addr_err;
        ren_done = bus.MEM_R_EN;
      end else begin
        low++;
        if (bus.WB_en) wb_leak++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    set_idle(1'b0, 32'h0, 5'd0);
  endtask

  logic [31:0] rv;
  int          low, leak;
  logic        wbd, errd, rend;

  initial begin
    rst = 1'b1;
    set_idle(1'b1, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_rdval", bus.MEM_read_value, 32'h0);
    chk("rst_wben", 32'(bus.WB_en), 32'd1);
    chk("rst_aerr", 32'(bus.addr_err), 32'd0);

    // Non-memory instruction passes straight through
    @(posedge clk);
    #1;
    set_idle(1'b1, 32'h7, 5'd5);
    @(negedge clk);
    chk("alu_ready", 32'(bus.ready), 32'd1);
    chk("alu_result", bus.ALU_result, 32'h7);
    chk("alu_dest", 32'(bus.Dest), 32'd5);
    chk("alu_rdval", bus.MEM_read_value, 32'h0);
    chk("alu_wben", 32'(bus.WB_en), 32'd1);

    @(posedge clk);
    #1;
    do_op("st1032", 1'b0, 1'b1, 32'd1032, 32'h1234_5678, rv, low, wbd, errd, rend, leak);
    chk("st1032_low", 32'(low), 32'(LAT + 1));
    chk("st1032_rdval", rv, 32'h0);
    chk("st1032_aerr", 32'(errd), 32'd0);

    do_op("ld1032", 1'b1, 1'b0, 32'd1032, 32'h0, rv, low, wbd, errd, rend, leak);
    chk("ld1032_low", 32'(low), 32'(LAT + 1));
    chk("ld1032_rdval", rv, 32'h1234_5678);
    chk("ld1032_wb_done", 32'(wbd), 32'd1);
    chk("ld1032_wb_busy", 32'(leak), 32'd0);
    chk("ld1032_ren", 32'(rend), 32'd1);

    // Read+write together is a store with no read data
    do_op("rw1036", 1'b1, 1'b1, 32'd1036, 32'h0BAD_F00D, rv, low, wbd, errd, rend, leak);
    chk("rw1036_low", 32'(low), 32'(LAT + 1));
    chk("rw1036_rdval", rv, 32'h0);

    // Reset lands on the commit edge: store must be dropped
    drive_op(1'b0, 1'b1, 32'd1036, 32'hAAAA_5555);
    repeat (LAT) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy_ready", 32'(bus.ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle(1'b0, 32'h0, 5'd0);
    @(negedge clk);
    chk("rstmid_ready", 32'(bus.ready), 32'd1);
    chk("rstmid_rdval", bus.MEM_read_value, 32'h0);
    @(posedge clk);
    #1;
    do_op("ld1036", 1'b1, 1'b0, 32'd1036, 32'h0, rv, low, wbd, errd, rend, leak);
    chk("ld1036_rdval", rv, 32'h0BAD_F00D);

    // Back-to-back store then load of the same word
    do_op("st1024", 1'b0, 1'b1, 32'd1024, 32'hCAFE_BABE, rv, low, wbd, errd, rend, leak);
    chk("st1024_low", 32'(low), 32'(LAT + 1));
    do_op("ld1024", 1'b1, 1'b0, 32'd1024, 32'h0, rv, low, wbd, errd, rend, leak);
    chk("ld1024_low", 32'(low), 32'(LAT + 1));
    chk("ld1024_rdval", rv, 32'hCAFE_BABE);

`ifdef MEM_ADDR_CHECK_EN
    do_op("ld1020", 1'b1, 1'b0, 32'd1020, 32'h0, rv, low, wbd, errd, rend, leak);
    chk("ld1020_low", 32'(low), 32'(LAT + 1));
    chk("ld1020_rdval", rv, 32'hDEAD_BEEF);
    chk("ld1020_aerr", 32'(errd), 32'd1);
    @(negedge clk);
    chk("aerr_after_done", 32'(bus.addr_err), 32'd0);
    @(posedge clk);
    #1;
    do_op("st1280", 1'b0, 1'b1, 32'd1280, 32'h1111_2222, rv, low, wbd, errd, rend, leak);
    chk("st1280_aerr", 32'(errd), 32'd1);
    do_op("ld1024b", 1'b1, 1'b0, 32'd1024, 32'h0, rv, low, wbd, errd, rend, leak);
    chk("ld1024b_rdval", rv, 32'hCAFE_BABE);
    chk("ld1024b_aerr", 32'(errd), 32'd0);
`else
    do_op("st1280", 1'b0, 1'b1, 32'd1280, 32'h1111_2222, rv, low, wbd, errd, rend, leak);
    chk("st1280_aerr", 32'(errd), 32'd0);
    do_op("ld1024b", 1'b1, 1'b0, 32'd1024, 32'h0, rv, low, wbd, errd, rend, leak);
    chk("ld1024b_rdval", rv, 32'h1111_2222);
    // 1020 maps to off = -4, i.e. word 63
    do_op("st1020", 1'b0, 1'b1, 32'd1020, 32'h5A5A_0F0F, rv, low, wbd, errd, rend, leak);
    do_op("ld1276", 1'b1, 1'b0, 32'd1276, 32'h0, rv, low, wbd, errd, rend, leak);
    chk("ld1276_rdval", rv, 32'h5A5A_0F0F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
